led_input_conditioner: RTL and testbench
========================================

Name: led_input_conditioner

Overview:
- Upstream stage of led_controller.
- Takes raw, asynchronous pedestrian-button and car-sensor inputs; synchronizes and debounces them.
- Latches each pedestrian press into a sticky request that holds until the controller acknowledges it, then enforces a re-request lockout.
- Drives led_controller's pedestrian_button and car_sensor inputs directly.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive cycles a synchronized input must differ from its stable value before the stable value updates (legal: 2 or more).
- LOCKOUT_CYCLES, 8: cycles after an ack during which new button presses are discarded (0 = no lockout).
- COUNT_WIDTH, 8: width of the accepted-request counter.

Ports:
- clk, input, 1: single system clock, rising edge.
- reset, input, 1: asynchronous, active-low reset (0 = reset asserted).
- button_raw, input, 1: raw pedestrian button, asynchronous, may bounce.
- car_raw, input, 1: raw car sensor, asynchronous, may bounce.
- ped_ack, input, 1: from the controller; level, sampled each edge; 1 = pedestrian phase served.
- pedestrian_button, output, 1: sticky pedestrian request (pending flag).
- car_sensor, output, 1: debounced car presence.
- in_lockout, output, 1: 1 while the lockout counter is nonzero.
- press_count, output, COUNT_WIDTH: accepted requests, saturating.

Behaviour:
- Reset (reset=0, asynchronous): all synchronizer flops, stable values, debounce counters, pedestrian_button, car_sensor, lockout counter and press_count clear to 0 immediately. Reset mid-debounce or mid-lockout discards all progress. Release takes effect at the first edge with reset=1.
- Synchronizer: per input, two flops (s1, s2). s2 is the synchronized value.
- Debouncer: per input, holds stable value d and counter cnt of width $clog2(DEBOUNCE_CYCLES).
  - At each edge where s2==d: cnt<=0.
  - At each edge where s2!=d: if cnt==DEBOUNCE_CYCLES-1 then d<=s2 and cnt<=0, else cnt<=cnt+1.
  - Any return of s2 to d before the count completes clears cnt (glitch rejected).
- Latency: raw input changes before edge 1 and is held. With DEBOUNCE_CYCLES=4, d updates at edge 6 (2 sync edges + 4 count edges).
- car_sensor = d_car, registered, with no extra latency.
- A button rise is the edge on which d_btn updates 0->1. A fall produces no event.
- Request logic, evaluated on each edge in priority order:
  1. ped_ack=1: pedestrian_button<=0; lockout<=LOCKOUT_CYCLES; any rise on the same edge is discarded and not counted. Ack while pedestrian_button=0 still loads the lockout.
  2. Rise while lockout!=0: discarded, not counted.
  3. Rise while lockout==0: pedestrian_button<=1; press_count<=press_count+1, saturating at 2^COUNT_WIDTH-1. A rise while already pending is counted; the flag stays 1.
- Lockout counter: decrements by 1 per edge while nonzero, except on an ack edge, which reloads it.
- in_lockout = (lockout!=0).
- pedestrian_button persists indefinitely until ack. It is unaffected by the button being held or released.
- car_sensor is independent of ack and lockout.

Test Plan:
- Reset then idle: assert reset=0 mid-cycle -> all outputs 0 immediately, without waiting for a clock edge. Release with raw inputs at 0 -> outputs stay 0 for 20 cycles.
- Clean press: button_raw 0->1 before edge 1, held -> pedestrian_button=1 and press_count=1 after edge 6; both remain after button_raw returns to 0.
- Bounce rejection: button_raw toggles 1,0,1,0 each cycle, then holds 0 -> pedestrian_button stays 0 and press_count stays 0. Repeat with car_raw -> car_sensor stays 0.
- Ack and lockout: pending=1, ped_ack=1 for one edge -> pedestrian_button=0 and in_lockout=1 for exactly 8 edges. A debounced press completing inside that window is ignored (count unchanged). A press completing after the window sets pending and increments the count.
- Simultaneous ack and rise on the same edge -> pedestrian_button=0, press_count unchanged, lockout=8.
- Saturation and car path: with COUNT_WIDTH=2, make 5 separated accepted presses -> press_count ends at 3. car_raw held 1 -> car_sensor=1 after edge 6; car_raw held 0 -> car_sensor=0 after a further 6 edges.

Source files
------------

// File: rtl/led_input_conditioner.sv
// led_input_conditioner: synchronizes and debounces the raw pedestrian-button
// and car-sensor inputs. Each accepted button press becomes a sticky request,
// which stays up until the controller acknowledges it. After an
// acknowledge, new presses are ignored for a lockout window.

// Two-flop synchronizer followed by a counting debouncer for one input.
// stable_o changes only after the synchronized value has differed from it for
// DEBOUNCE_CYCLES consecutive edges. rise_o is high during the cycle whose
// closing edge moves stable_o from 0 to 1.
module led_ic_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_i,
    output logic stable_o,
    output logic rise_o
);

    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          s1_q, s2_q;
    logic          d_q, d_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          cnt_done;

    assign cnt_done = (cnt_q == CNT_LAST);

    // Two-stage synchronizer for the asynchronous raw input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= raw_i;
            s2_q <= s1_q;
        end
    end

    // Debounce next state: count disagreeing edges and clear on any agreement.
    always_comb begin
        d_d   = d_q;
        cnt_d = '0;
        if (s2_q != d_q) begin
            if (cnt_done) begin
                d_d   = s2_q;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Debounce state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_q   <= 1'b0;
            cnt_q <= '0;
        end else begin
            d_q   <= d_d;
            cnt_q <= cnt_d;
        end
    end

    assign stable_o = d_q;
    assign rise_o   = s2_q & ~d_q & cnt_done;

endmodule

module led_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int LOCKOUT_CYCLES  = 8,
    parameter int COUNT_WIDTH     = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   button_raw,
    input  logic                   car_raw,
    input  logic                   ped_ack,
    output logic                   pedestrian_button,
    output logic                   car_sensor,
    output logic                   in_lockout,
    output logic [COUNT_WIDTH-1:0] press_count
);

    // The lockout counter must hold LOCKOUT_CYCLES. It keeps at least one bit
    // so that the design still elaborates when there is no lockout.
    localparam int LW = (LOCKOUT_CYCLES > 0) ? $clog2(LOCKOUT_CYCLES + 1) : 1;
    localparam logic [LW-1:0] LOCK_LOAD = LW'(LOCKOUT_CYCLES);

    logic                   btn_stable, btn_rise;
    logic                   car_stable, car_rise_unused;

    logic                   pend_q, pend_d;
    logic [LW-1:0]          lock_q, lock_d;
    logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                   lock_active;

    led_ic_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_db (
        .clk      (clk),
        .rst_n    (reset),
        .raw_i    (button_raw),
        .stable_o (btn_stable),
        .rise_o   (btn_rise)
    );

    led_ic_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_car_db (
        .clk      (clk),
        .rst_n    (reset),
        .raw_i    (car_raw),
        .stable_o (car_stable),
        .rise_o   (car_rise_unused)
    );

    assign lock_active = (lock_q != '0);

    // Request priority: an ack wins over any rise on the same edge. A rise
    // during lockout is dropped. Otherwise the rise sets the pending flag and
    // is counted, with the count saturating.
    always_comb begin
        pend_d = pend_q;
        cnt_d  = cnt_q;
        lock_d = lock_active ? (lock_q - 1'b1) : lock_q;
        if (ped_ack) begin
            pend_d = 1'b0;
            lock_d = LOCK_LOAD;
        end else if (btn_rise && !lock_active) begin
            pend_d = 1'b1;
            if (cnt_q != {COUNT_WIDTH{1'b1}}) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Request, lockout and press-count registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_q <= 1'b0;
            lock_q <= '0;
            cnt_q  <= '0;
        end else begin
            pend_q <= pend_d;
            lock_q <= lock_d;
            cnt_q  <= cnt_d;
        end
    end

    // The stable value of the button is used only through its rise event.
    logic btn_stable_unused;
    assign btn_stable_unused = btn_stable;

    assign pedestrian_button = pend_q;
    assign car_sensor        = car_stable;
    assign in_lockout        = lock_active;
    assign press_count       = cnt_q;

endmodule

// File: tb/tb_led_input_conditioner.sv
// Directed bench for led_input_conditioner. A second instance with a 2-bit
// press counter covers saturation.
module tb_led_input_conditioner;

    logic       clk = 1'b0;
    logic       reset;
    logic       reset_sat;
    logic       button_raw;
    logic       car_raw;
    logic       ped_ack;
    logic       pedestrian_button, car_sensor, in_lockout;
    logic [7:0] press_count;
    logic       sat_ped, sat_car, sat_lock;
    logic [1:0] sat_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    led_input_conditioner dut (
        .clk               (clk),
        .reset             (reset),
        .button_raw        (button_raw),
        .car_raw           (car_raw),
        .ped_ack           (ped_ack),
        .pedestrian_button (pedestrian_button),
        .car_sensor        (car_sensor),
        .in_lockout        (in_lockout),
        .press_count       (press_count)
    );

    led_input_conditioner #(.COUNT_WIDTH(2)) dut_sat (
        .clk               (clk),
        .reset             (reset_sat),
        .button_raw        (button_raw),
        .car_raw           (car_raw),
        .ped_ack           (ped_ack),
        .pedestrian_button (sat_ped),
        .car_sensor        (sat_car),
        .in_lockout        (sat_lock),
        .press_count       (sat_count)
    );

    // Advance n rising edges, then settle 1 time unit past the last one.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic ped, input logic car,
                           input logic lock, input logic [7:0] cnt);
        chk({tag, ".ped"},   32'(pedestrian_button), 32'(ped));
        chk({tag, ".car"},   32'(car_sensor),        32'(car));
        chk({tag, ".lock"},  32'(in_lockout),        32'(lock));
        chk({tag, ".count"}, 32'(press_count),       32'(cnt));
    endtask

    // One accepted press: rise at the 6th edge, then release and let it settle.
    task automatic press_release();
        button_raw = 1'b1;
        tick(6);
        button_raw = 1'b0;
        tick(8);
    endtask

    initial begin
        reset      = 1'b1;
        reset_sat  = 1'b1;
        button_raw = 1'b0;
        car_raw    = 1'b0;
        ped_ack    = 1'b0;

        // Asynchronous reset asserted between clock edges.
        #2;
        reset     = 1'b0;
        reset_sat = 1'b0;
        #1;
        chk_all("reset_async", 1'b0, 1'b0, 1'b0, 8'd0);
        #4;
        reset     = 1'b1;
        reset_sat = 1'b1;

        // Idle for 20 cycles.
        for (int i = 0; i < 20; i++) begin
            tick(1);
            chk_all("idle", 1'b0, 1'b0, 1'b0, 8'd0);
        end

        // Bounce on the button: 1,0,1,0, then hold 0.
        button_raw = 1'b1; tick(1);
        button_raw = 1'b0; tick(1);
        button_raw = 1'b1; tick(1);
        button_raw = 1'b0; tick(10);
        chk_all("btn_bounce", 1'b0, 1'b0, 1'b0, 8'd0);

        // Bounce on the car sensor.
        car_raw = 1'b1; tick(1);
        car_raw = 1'b0; tick(1);
        car_raw = 1'b1; tick(1);
        car_raw = 1'b0; tick(10);
        chk_all("car_bounce", 1'b0, 1'b0, 1'b0, 8'd0);

        // Clean press: the request appears at edge 6 and not before.
        button_raw = 1'b1;
        tick(5);
        chk("press_edge5.ped", 32'(pedestrian_button), 32'd0);
        tick(1);
        chk_all("press_edge6", 1'b1, 1'b0, 1'b0, 8'd1);
        button_raw = 1'b0;
        tick(10);
        chk_all("press_released", 1'b1, 1'b0, 1'b0, 8'd1);

        // Ack opens an 8-edge lockout. A press that completes inside it is dropped.
        ped_ack = 1'b1;
        tick(1);
        ped_ack    = 1'b0;
        button_raw = 1'b1;
        chk_all("ack_edge", 1'b0, 1'b0, 1'b1, 8'd1);
        for (int i = 1; i <= 8; i++) begin
            tick(1);
            chk("lockout_window", 32'(in_lockout), (i < 8) ? 32'd1 : 32'd0);
        end
        chk_all("lockout_press_dropped", 1'b0, 1'b0, 1'b0, 8'd1);
        button_raw = 1'b0;
        tick(8);
        chk_all("lockout_release", 1'b0, 1'b0, 1'b0, 8'd1);

        // A press after the window is accepted.
        button_raw = 1'b1;
        tick(6);
        chk_all("post_lockout_press", 1'b1, 1'b0, 1'b0, 8'd2);
        button_raw = 1'b0;
        tick(8);

        // Ack and rise on the same edge: the ack wins and the press is not counted.
        button_raw = 1'b1;
        tick(5);
        ped_ack = 1'b1;
        tick(1);
        ped_ack    = 1'b0;
        button_raw = 1'b0;
        chk_all("ack_rise_same_edge", 1'b0, 1'b0, 1'b1, 8'd2);
        tick(7);
        chk("ack_rise_lock_7", 32'(in_lockout), 32'd1);
        tick(1);
        chk("ack_rise_lock_8", 32'(in_lockout), 32'd0);
        chk("ack_rise_count", 32'(press_count), 32'd2);

        // An ack with nothing pending still loads the lockout.
        ped_ack = 1'b1;
        tick(1);
        ped_ack = 1'b0;
        chk_all("idle_ack", 1'b0, 1'b0, 1'b1, 8'd2);
        tick(8);
        chk("idle_ack_expire", 32'(in_lockout), 32'd0);

        // Saturation on the 2-bit instance after a fresh reset of that instance.
        reset_sat = 1'b0;
        #1;
        chk("sat_reset", 32'(sat_count), 32'd0);
        reset_sat = 1'b1;
        tick(1);
        for (int k = 1; k <= 5; k++) begin
            press_release();
            chk("sat_count", 32'(sat_count), (k < 3) ? 32'(k) : 32'd3);
            chk("main_count", 32'(press_count), 32'(2 + k));
            chk("main_pending", 32'(pedestrian_button), 32'd1);
        end

        // Car path: rise at edge 6, fall 6 edges after release.
        car_raw = 1'b1;
        tick(5);
        chk("car_rise_edge5", 32'(car_sensor), 32'd0);
        tick(1);
        chk("car_rise_edge6", 32'(car_sensor), 32'd1);
        car_raw = 1'b0;
        tick(5);
        chk("car_fall_edge5", 32'(car_sensor), 32'd1);
        tick(1);
        chk("car_fall_edge6", 32'(car_sensor), 32'd0);

        // Car presence is independent of ack and lockout.
        car_raw = 1'b1;
        tick(6);
        ped_ack = 1'b1;
        tick(1);
        ped_ack = 1'b0;
        chk_all("busy_state", 1'b0, 1'b1, 1'b1, 8'd7);

        // Reset mid-cycle and mid-lockout clears everything at once.
        #3;
        reset   = 1'b0;
        car_raw = 1'b0;
        #1;
        chk_all("reset_mid", 1'b0, 1'b0, 1'b0, 8'd0);
        reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            chk_all("post_reset_idle", 1'b0, 1'b0, 1'b0, 8'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
